// File: rtl/fp_gray_pack_if.sv
// fp_gray_pack_if: request/result bundle between the multiplier stage,
// the grayscale pack back-end and the pixel writer.
interface fp_gray_pack_if #(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned MANT_WIDTH  = 24,
    parameter int unsigned EXP_WIDTH   = 8
);
    logic                        start_i;
    logic [MANT_WIDTH-1:0]       mant_i_R;
    logic [MANT_WIDTH-1:0]       mant_i_G;
    logic [MANT_WIDTH-1:0]       mant_i_B;
    logic signed [EXP_WIDTH-1:0] exp_i_R;
    logic signed [EXP_WIDTH-1:0] exp_i_G;
    logic signed [EXP_WIDTH-1:0] exp_i_B;
    logic [PIXEL_WIDTH-1:0]      pixel_o;
    logic                        sat_o;
    logic                        busy_o;
    logic                        done_o;

    modport master (
        output start_i, mant_i_R, mant_i_G, mant_i_B, exp_i_R, exp_i_G, exp_i_B,
        input  pixel_o, sat_o, busy_o, done_o
    );

    modport slave (
        input  start_i, mant_i_R, mant_i_G, mant_i_B, exp_i_R, exp_i_G, exp_i_B,
        output pixel_o, sat_o, busy_o, done_o
    );
endinterface

// File: rtl/fp_gray_pack.sv
// fp_gray_pack: converts three normalized channel products (mantissa plus
// signed unbiased exponent) to Q.24 fixed point, accumulates R+G+B one
// channel per cycle, then rounds/truncates and saturates to an 8-bit pixel.
// Optional feature: define GRAY_ROUND_EN to add a half-LSB bias before the
// fractional bits are dropped (round half up); otherwise plain truncation.
module fp_gray_pack #(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned MANT_WIDTH  = 24,
    parameter int unsigned EXP_WIDTH   = 8,
    parameter int unsigned FRAC_BITS   = 24,
    parameter int unsigned ACC_WIDTH   = 36
) (
    input  logic          clk_i_gray_pack,
    input  logic          rst_i_gray_pack,
    fp_gray_pack_if.slave bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ACC_R = 3'd1;
    localparam logic [2:0] ACC_G = 3'd2;
    localparam logic [2:0] ACC_B = 3'd3;
    localparam logic [2:0] ROUND = 3'd4;

    localparam logic signed [EXP_WIDTH-1:0] OVF_EXP = EXP_WIDTH'(10);
    localparam logic [ACC_WIDTH-1:0] PIX_MAX = ACC_WIDTH'((1 << PIXEL_WIDTH) - 1);
`ifdef GRAY_ROUND_EN
    localparam logic [ACC_WIDTH-1:0] ROUND_BIAS = ACC_WIDTH'(1) << (FRAC_BITS - 1);
`else
    localparam logic [ACC_WIDTH-1:0] ROUND_BIAS = '0;
`endif

    logic [2:0]                  state;
    logic [ACC_WIDTH-1:0]        acc;
    logic                        sat_flag;
    logic [MANT_WIDTH-1:0]       mant_r, mant_g, mant_b;
    logic signed [EXP_WIDTH-1:0] exp_r, exp_g, exp_b;
    logic [PIXEL_WIDTH-1:0]      pixel_q;
    logic                        sat_q;
    logic                        done_q;

    logic [MANT_WIDTH-1:0]       mant_sel;
    logic signed [EXP_WIDTH-1:0] exp_sel;
    logic signed [EXP_WIDTH:0]   sh;
    logic [EXP_WIDTH:0]          sh_mag;
    logic                        ch_ovf;
    logic [ACC_WIDTH-1:0]        contrib;
    logic [ACC_WIDTH-1:0]        int_part;

    // Select the latched channel for this cycle and scale it into Q.24.
    always_comb begin
        mant_sel = mant_r;
        exp_sel  = exp_r;
        case (state)
            ACC_G: begin
                mant_sel = mant_g;
                exp_sel  = exp_g;
            end
            ACC_B: begin
                mant_sel = mant_b;
                exp_sel  = exp_b;
            end
            default: begin
                mant_sel = mant_r;
                exp_sel  = exp_r;
            end
        endcase

        // value * 2^24 = mant * 2^(exp + 1)
        sh     = {exp_sel[EXP_WIDTH-1], exp_sel} + (EXP_WIDTH + 1)'(1);
        sh_mag = -sh;
        ch_ovf = (exp_sel >= OVF_EXP) && (mant_sel != '0);

        if (ch_ovf) begin
            contrib = '0;
        end else if (!sh[EXP_WIDTH]) begin
            contrib = ACC_WIDTH'(mant_sel) << sh[EXP_WIDTH-1:0];
        end else if (sh_mag > (EXP_WIDTH + 1)'(FRAC_BITS)) begin
            contrib = '0;
        end else begin
            contrib = ACC_WIDTH'(mant_sel) >> sh_mag;
        end
    end

    // Integer part of the (optionally biased) accumulated sum.
    always_comb begin
        int_part = (acc + ROUND_BIAS) >> FRAC_BITS;
    end

    // Transaction sequencer: latch, accumulate three channels, round/saturate.
    always_ff @(posedge clk_i_gray_pack or posedge rst_i_gray_pack) begin
        if (rst_i_gray_pack) begin
            state    <= IDLE;
            acc      <= '0;
            sat_flag <= 1'b0;
            mant_r   <= '0;
            mant_g   <= '0;
            mant_b   <= '0;
            exp_r    <= '0;
            exp_g    <= '0;
            exp_b    <= '0;
            pixel_q  <= '0;
            sat_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        mant_r   <= bus.mant_i_R;
                        mant_g   <= bus.mant_i_G;
                        mant_b   <= bus.mant_i_B;
                        exp_r    <= bus.exp_i_R;
                        exp_g    <= bus.exp_i_G;
                        exp_b    <= bus.exp_i_B;
                        acc      <= '0;
                        sat_flag <= 1'b0;
                        state    <= ACC_R;
                    end
                end
                // The three accumulate states share one datapath; the state
                // encodings are consecutive so ACC_B + 1 lands on ROUND.
                ACC_R, ACC_G, ACC_B: begin
                    acc <= acc + contrib;
                    if (ch_ovf) begin
                        sat_flag <= 1'b1;
                    end
                    state <= state + 3'd1;
                end
                ROUND: begin
                    if ((int_part > PIX_MAX) || sat_flag) begin
                        pixel_q <= '1;
                        sat_q   <= 1'b1;
                    end else begin
                        pixel_q <= int_part[PIXEL_WIDTH-1:0];
                        sat_q   <= 1'b0;
                    end
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Drive the result side of the bundle from registered state.
    always_comb begin
        bus.pixel_o = pixel_q;
        bus.sat_o   = sat_q;
        bus.busy_o  = (state != IDLE);
        bus.done_o  = done_q;
    end

endmodule

// File: tb/tb_fp_gray_pack.sv
// tb_fp_gray_pack: directed vectors with hand-computed results; the stimulus
// thread pushes expected pixels into a queue and a monitor pops on done_o.
module tb_fp_gray_pack;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fp_gray_pack_if bus ();

    fp_gray_pack dut (
        .clk_i_gray_pack (clk),
        .rst_i_gray_pack (rst),
        .bus             (bus)
    );

    typedef struct packed {
        logic [7:0] pix;
        logic       sat;
    } exp_t;

`ifdef GRAY_ROUND_EN
    localparam logic [7:0] HALF_PIX = 8'd1;
`else
    localparam logic [7:0] HALF_PIX = 8'd0;
`endif

    exp_t        sb_q[$];
    exp_t        mon_e;
    int unsigned n_cmp    = 0;
    int unsigned n_err    = 0;
    int unsigned cyc      = 0;
    int unsigned done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Scoreboard monitor: every done_o pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.done_o === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done_o=1, expected no result (t=%0t)", $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pixel", 32'(bus.pixel_o), 32'(mon_e.pix));
                chk("sat", 32'(bus.sat_o), 32'(mon_e.sat));
                chk("busy_at_done", 32'(bus.busy_o), 32'd0);
            end
        end
    end

    task automatic wait_done(output int unsigned at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done_o in 20 cycles, expected one (t=%0t)", $time);
        end
    endtask

    task automatic drive(input logic [23:0] mr, input logic signed [7:0] er,
                         input logic [23:0] mg, input logic signed [7:0] eg,
                         input logic [23:0] mb, input logic signed [7:0] eb);
        bus.mant_i_R = mr; bus.exp_i_R = er;
        bus.mant_i_G = mg; bus.exp_i_G = eg;
        bus.mant_i_B = mb; bus.exp_i_B = eb;
    endtask

    // One full transaction with latency check; inputs scrambled after accept.
    task automatic issue(input logic [23:0] mr, input logic signed [7:0] er,
                         input logic [23:0] mg, input logic signed [7:0] eg,
                         input logic [23:0] mb, input logic signed [7:0] eb,
                         input logic [7:0] ep, input logic es);
        int unsigned acc_cyc;
        int unsigned dc;
        bit          ok;
        @(negedge clk);
        drive(mr, er, mg, eg, mb, eb);
        bus.start_i = 1'b1;
        sb_q.push_back('{pix: ep, sat: es});
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.start_i = 1'b0;
        drive(24'hFFFFFF, 8'sd9, 24'hFFFFFF, 8'sd9, 24'hFFFFFF, 8'sd9);
        @(negedge clk);
        chk("busy_after_accept", 32'(bus.busy_o), 32'd1);
        wait_done(dc, ok);
        if (ok) chk("latency", dc - acc_cyc, 32'd4);
    endtask

    initial begin
        int unsigned d1;
        int unsigned d2;
        int unsigned dc0;
        int unsigned acc_cyc;
        bit          ok;

        bus.start_i = 1'b0;
        drive('0, '0, '0, '0, '0, '0);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pixel", 32'(bus.pixel_o), 32'd0);
        chk("rst_sat", 32'(bus.sat_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        rst = 1'b0;

        // 76 + 150 + 29 = 255 exactly: ceiling without saturation
        issue(24'h980000, 8'sd6, 24'h960000, 8'sd7, 24'hE80000, 8'sd4, 8'd255, 1'b0);
        // 0.5 alone: rounding decides 0 or 1
        issue(24'h800000, -8'sd1, 24'h0, 8'sd0, 24'h0, 8'sd0, HALF_PIX, 1'b0);
        // 3 x 128 = 384 saturates
        issue(24'h800000, 8'sd7, 24'h800000, 8'sd7, 24'h800000, 8'sd7, 8'd255, 1'b1);
        // exponent overflow on one channel
        issue(24'h800000, 8'sd10, 24'h0, 8'sd0, 24'h0, 8'sd0, 8'd255, 1'b1);
        // R underflows, G = 8.0
        issue(24'hFFFFFF, -8'sd30, 24'h800000, 8'sd3, 24'h0, 8'sd0, 8'd8, 1'b0);
        // mant 0 with huge exponent is not an overflow: 0 + 1.0 + 0.25 -> 1
        issue(24'h0, 8'sd100, 24'h800000, 8'sd0, 24'h800000, -8'sd2, 8'd1, 1'b0);
        // exp 9 (512.0) is not a channel overflow but still saturates the sum
        issue(24'h800000, 8'sd9, 24'h0, 8'sd0, 24'h0, 8'sd0, 8'd255, 1'b1);

        // start pulses during a busy transaction are ignored
        @(negedge clk);
        drive(24'hA00000, 8'sd3, 24'hA00000, 8'sd3, 24'hA00000, 8'sd3);
        bus.start_i = 1'b1;
        sb_q.push_back('{pix: 8'd30, sat: 1'b0});
        dc0 = done_cnt;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.start_i = 1'b0;
        drive(24'h800000, 8'sd7, 24'h800000, 8'sd7, 24'h800000, 8'sd7);
        @(negedge clk);
        bus.start_i = 1'b1;
        repeat (2) @(negedge clk);
        bus.start_i = 1'b0;
        wait_done(d1, ok);
        if (ok) chk("ignore_latency", d1 - acc_cyc, 32'd4);
        repeat (8) @(negedge clk);
        chk("ignore_one_done", done_cnt - dc0, 32'd1);

        // start held high: re-accepted in the done_o cycle
        @(negedge clk);
        drive(24'hA00000, 8'sd3, 24'hA00000, 8'sd3, 24'hA00000, 8'sd3);
        bus.start_i = 1'b1;
        sb_q.push_back('{pix: 8'd30, sat: 1'b0});
        wait_done(d1, ok);
        drive(24'hFFFFFF, -8'sd30, 24'h800000, 8'sd3, 24'h0, 8'sd0);
        sb_q.push_back('{pix: 8'd8, sat: 1'b0});
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        wait_done(d2, ok);
        if (ok) chk("b2b_done_spacing", d2 - d1, 32'd5);

        // reset during ACC_G: immediate clear, no done pulse
        @(negedge clk);
        drive(24'hA00000, 8'sd3, 24'hA00000, 8'sd3, 24'hA00000, 8'sd3);
        bus.start_i = 1'b1;
        dc0 = done_cnt;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        bus.start_i = 1'b1;
        #1;
        chk("midrst_pixel", 32'(bus.pixel_o), 32'd0);
        chk("midrst_sat", 32'(bus.sat_o), 32'd0);
        chk("midrst_busy", 32'(bus.busy_o), 32'd0);
        chk("midrst_done", 32'(bus.done_o), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_beats_start", 32'(bus.busy_o), 32'd0);
        bus.start_i = 1'b0;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_no_done", done_cnt - dc0, 32'd0);

        issue(24'hA00000, 8'sd3, 24'hA00000, 8'sd3, 24'hA00000, 8'sd3, 8'd30, 1'b0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
